// File: rtl/game_frame_control.sv
// game_frame_control: paces the playfield loop to a fixed tick and sequences the phase strobes.
module game_frame_control #(
  parameter int TICK_DIV  = 833333,
  parameter int COLL_WAIT = 2,
  parameter int TIMEOUT   = 65535
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        map_draw_done,
  input  logic        link_draw_done,
  output logic        init,
  output logic        idle,
  output logic        reg_action,
  output logic        apply_action,
  output logic        draw_map,
  output logic        draw_link,
  output logic        frame_overrun,
  output logic        draw_timeout,
  output logic [15:0] frame_count
);
  localparam int TW   = $clog2(TICK_DIV);
  localparam int CMAX = TIMEOUT > COLL_WAIT ? TIMEOUT : COLL_WAIT;
  localparam int CW   = $clog2(CMAX + 1);
  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REG, S_COLL, S_APPLY, S_DMAP, S_DLINK} state_t;
  state_t r_state, w_next;
  logic [TW-1:0] r_tick_cnt;
  logic [CW-1:0] r_cnt;
  logic w_tick, w_draw, w_done, w_abort, w_enter;
  // r_cnt doubles as the collision countdown and the draw residency count; a zero count in a
  // draw state is the first cycle, where a done left over from the previous frame is ignored.
  always_comb begin
    w_tick  = r_tick_cnt == TW'(TICK_DIV - 1);
    w_draw  = r_state == S_DMAP || r_state == S_DLINK;
    w_done  = r_cnt != '0 && (r_state == S_DMAP ? map_draw_done : link_draw_done);
    w_abort = w_draw && !w_done && r_cnt == CW'(TIMEOUT - 1);
    w_next  = r_state;
    case (r_state)
      S_INIT:  w_next = start ? S_IDLE : S_INIT;
      S_IDLE:  w_next = w_tick ? S_REG : S_IDLE;
      S_REG:   w_next = S_COLL;
      S_COLL:  w_next = r_cnt == '0 ? S_APPLY : S_COLL;
      S_APPLY: w_next = S_DMAP;
      S_DMAP:  w_next = w_done ? S_DLINK : w_abort ? S_IDLE : S_DMAP;
      S_DLINK: w_next = (w_done || w_abort) ? S_IDLE : S_DLINK;
      default: w_next = S_INIT;
    endcase
    w_enter = w_next != r_state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_INIT;
      r_tick_cnt    <= '0;
      r_cnt         <= '0;
      {init, idle, reg_action, apply_action, draw_map, draw_link} <= 6'b100000;
      frame_overrun <= 1'b0;
      draw_timeout  <= 1'b0;
      frame_count   <= '0;
    end else begin
      r_state    <= w_next;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      r_cnt      <= w_next == S_COLL ? (w_enter ? CW'(COLL_WAIT - 1) : r_cnt - CW'(1))
                  : (w_draw && !w_enter) ? r_cnt + CW'(1) : '0;
      init         <= w_next == S_INIT;
      idle         <= w_next == S_IDLE;
      reg_action   <= w_next == S_REG;
      apply_action <= w_next == S_APPLY;
      draw_map     <= w_next == S_DMAP;
      draw_link    <= w_next == S_DLINK;
      if (w_tick && r_state != S_IDLE && r_state != S_INIT) frame_overrun <= 1'b1;
      if (w_abort) draw_timeout <= 1'b1;
      if (r_state == S_DLINK && w_done) frame_count <= frame_count + 16'd1;
    end
  end
endmodule
